// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file constants, write-back request type and address decode helper
//
// Purpose: common definitions for the execute/load stages and the write-back arbiter.
// Contents:
//   REG_ADDR_W  width of a register index (5)
//   NUM_REGS    number of architectural registers (32)
//   XLEN        data width of the write-back request type
//   wb_req_t    {rd, data} write-back request
//   reg_onehot  one-hot decode of a register index
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with last-grant register
//
// Purpose: grants one of two requesters per cycle; on a tie the requester that
// did not win last time is chosen.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset (last grant resets to B so A wins first tie)
//   req_a_i in   requester A valid
//   req_b_i in   requester B valid
//   gnt_a_o out  combinational grant to A
//   gnt_b_o out  combinational grant to B
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // 0 = A won last, 1 = B won last
  logic last_q;
  logic last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // A wins when alone, or on a tie if B was served last.
  always_comb begin
    gnt_a_o = req_a_i & (~req_b_i | last_q);
    gnt_b_o = req_b_i & (~req_a_i | ~last_q);
  end

  // Grants are transfers (ready == grant), so history moves only when one fires.
  always_comb begin
    last_d = last_q;
    if (gnt_a_o) begin
      last_d = 1'b0;
    end else if (gnt_b_o) begin
      last_d = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the single regfile write port
//
// Purpose: merges ALU (A) and load (B) write-backs onto one registered regfile
// write port, suppresses writes to x0, exports a pending-write mask and a
// saturating contention counter.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   a_valid, a_rd, a_data, a_ready requester A handshake
//   b_valid, b_rd, b_data, b_ready requester B handshake
//   wr_en, wr_addr, wr_data       registered regfile write port
//   pend_mask                     one-hot of wr_addr while wr_en is high
//   contend_cnt                   saturating count of cycles with both valid
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [WIDTH-1:0]      a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [WIDTH-1:0]      b_data,
  output logic                  b_ready,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic [CNT_W-1:0]      contend_cnt
);

  logic                  wr_en_q,   wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .gnt_a_o (a_ready),
    .gnt_b_o (b_ready)
  );

  // Output stage: never back-pressured, so a grant is always a transfer.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (a_ready) begin
      wr_addr_d = a_rd;
      wr_data_d = a_data;
      wr_en_d   = (a_rd != '0);
    end else if (b_ready) begin
      wr_addr_d = b_rd;
      wr_data_d = b_data;
      wr_en_d   = (b_rd != '0);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (a_valid && b_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign contend_cnt = cnt_q;
  assign pend_mask   = wr_en_q ? reg_onehot(wr_addr_q) : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - table-driven self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             a_valid;
  logic [4:0]       a_rd;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [4:0]       b_rd;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [31:0]      pend_mask;
  logic [CNT_W-1:0] contend_cnt;

  int tests;
  int fails;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pend_mask   (pend_mask),
    .contend_cnt (contend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        ea;
    logic        eb;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [31:0] epm;
    logic [3:0]  ecnt;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    //           av ard   ad            bv brd   bd            ea eb we wa    wd            pm            cnt
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        4'd0};
    vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h20,       4'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,       1'b0, 1'b1, 1'b1, 5'd7, 32'h77,       32'h80,       4'd0};
    vecs[3]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b1, 1'b0, 1'b1, 5'd1, 32'hA1,       32'h2,        4'd1};
    vecs[4]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b0, 1'b1, 1'b1, 5'd2, 32'hB2,       32'h4,        4'd2};
    vecs[5]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b1, 1'b0, 1'b1, 5'd1, 32'hA1,       32'h2,        4'd3};
    vecs[6]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b0, 1'b1, 1'b1, 5'd2, 32'hB2,       32'h4,        4'd4};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd2, 32'hB2,       32'h0,        4'd4};
    vecs[8]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 32'h1234,     32'h0,        4'd4};
    vecs[9]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB2,       1'b0, 1'b1, 1'b1, 5'd2, 32'hB2,       32'h4,        4'd5};
    vecs[10] = '{1'b1, 5'd9, 32'h1,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd9, 32'h1,        32'h200,      4'd5};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h2,        1'b0, 1'b1, 1'b1, 5'd9, 32'h2,        32'h200,      4'd5};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd9, 32'h2,        32'h0,        4'd5};

    // Reset state
    #12;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_cnt", {28'd0, contend_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd);
      #1;
      chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].ea});
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].eb});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vecs[i].ewe});
      chk($sformatf("v%0d_wr_addr", i), {27'd0, wr_addr}, {27'd0, vecs[i].ewa});
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].ewd);
      chk($sformatf("v%0d_pend", i), pend_mask, vecs[i].epm);
      chk($sformatf("v%0d_cnt", i), {28'd0, contend_cnt}, {28'd0, vecs[i].ecnt});
    end

    // Counter saturation: 20 tie cycles from a fresh reset
    do_reset();
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 13) chk("sat_cnt_14", {28'd0, contend_cnt}, 32'd14);
    end
    chk("sat_cnt_final", {28'd0, contend_cnt}, 32'hF);

    // Asynchronous reset while a write is pending
    do_reset();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk("ar_wr_en_before", {31'd0, wr_en}, 32'd1);
    chk("ar_pend_before", pend_mask, 32'h8);
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
    #1;
    chk("ar_tie_b_before", {31'd0, b_ready}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en_async", {31'd0, wr_en}, 32'd0);
    chk("ar_pend_async", pend_mask, 32'd0);
    chk("ar_a_ready_in_reset", {31'd0, a_ready}, 32'd1);
    chk("ar_b_ready_in_reset", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_tie_a_after", {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("ar_wr_addr_after", {27'd0, wr_addr}, 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
